// File: rtl/result_plot_buffer_pkg.sv
// Shared constants, state encoding and sizing helpers for the result plot buffer.
package result_plot_buffer_pkg;

   localparam int unsigned DEF_WIDTH_BITS  = 8;
   localparam int unsigned DEF_HEIGHT_BITS = 8;
   localparam int unsigned DEF_DEPTH_BITS  = 4;

   // Entry layout is {row, col, data}
   function automatic int unsigned entry_bits(input int unsigned w, input int unsigned h);
      return w + h + 1;
   endfunction

   function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
      return 32'd1 << (w + h);
   endfunction

   localparam int unsigned ENTRY_BITS   = entry_bits(DEF_WIDTH_BITS, DEF_HEIGHT_BITS);
   localparam int unsigned FIFO_DEPTH   = 2 ** DEF_DEPTH_BITS;
   localparam int unsigned FRAME_PIXELS = frame_pixels(DEF_WIDTH_BITS, DEF_HEIGHT_BITS);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_PLOT  = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/result_plot_buffer_if.sv
// Pixel input stream and plot handshake between threshold unit, buffer and VGA adapter.
interface result_plot_buffer_if
   import result_plot_buffer_pkg::*;
#(
   parameter int unsigned WIDTH_BITS  = DEF_WIDTH_BITS,
   parameter int unsigned HEIGHT_BITS = DEF_HEIGHT_BITS
);
   logic                              iClear;
   logic [WIDTH_BITS-1:0]             iCol;
   logic [HEIGHT_BITS-1:0]            iRow;
   logic                              iData;
   logic                              iWren;
   logic                              oFull;
   logic [WIDTH_BITS-1:0]             oX;
   logic [HEIGHT_BITS-1:0]            oY;
   logic [2:0]                        oR;
   logic [2:0]                        oG;
   logic [2:0]                        oB;
   logic                              oPlot;
   logic                              iReady;
   logic [WIDTH_BITS+HEIGHT_BITS:0]   oWhiteCount;
   logic                              oFinished;
   logic                              oOverflow;

   modport master (
      output iClear, iCol, iRow, iData, iWren, iReady,
      input  oFull, oX, oY, oR, oG, oB, oPlot, oWhiteCount, oFinished, oOverflow
   );

   modport slave (
      input  iClear, iCol, iRow, iData, iWren, iReady,
      output oFull, oX, oY, oR, oG, oB, oPlot, oWhiteCount, oFinished, oOverflow
   );

endinterface

// File: rtl/result_plot_buffer_plot_fifo.sv
// Single-clock FIFO with registered full/empty flags and combinational head output.
module plot_fifo #(
   parameter int unsigned DATA_BITS  = 17,
   parameter int unsigned DEPTH_BITS = 4
) (
   input  logic                  clock,
   input  logic                  not_reset,
   input  logic                  clear,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_BITS-1:0]  din,
   output logic [DATA_BITS-1:0]  dout,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_BITS:0]   count
);
   localparam int unsigned DEPTH    = 2 ** DEPTH_BITS;
   localparam int unsigned CNT_BITS = DEPTH_BITS + 1;

   logic [DATA_BITS-1:0]  mem [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;
   logic [CNT_BITS-1:0]   count_d;

   // A push into a full FIFO is legal only when the head leaves in the same cycle
   always_comb begin
      do_pop  = pop && !empty && !clear;
      do_push = push && (!full || do_pop) && !clear;
      count_d = count;
      if (do_push && !do_pop) begin
         count_d = count + CNT_BITS'(1);
      end else if (!do_push && do_pop) begin
         count_d = count - CNT_BITS'(1);
      end
      if (clear) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_BITS'(1);
         end
         count <= count_d;
         full  <= (count_d == CNT_BITS'(DEPTH));
         empty <= (count_d == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/result_plot_buffer.sv
// Buffers the binary result pixel stream and hands it one pixel at a time to the VGA adapter,
// counting white and completed pixels for the frame.
module result_plot_buffer
   import result_plot_buffer_pkg::*;
#(
   parameter int unsigned WIDTH_BITS  = DEF_WIDTH_BITS,
   parameter int unsigned HEIGHT_BITS = DEF_HEIGHT_BITS,
   parameter int unsigned DEPTH_BITS  = DEF_DEPTH_BITS
) (
   input  logic                 clock,
   input  logic                 not_reset,
   result_plot_buffer_if.slave  bus
);
   localparam int unsigned EBITS  = entry_bits(WIDTH_BITS, HEIGHT_BITS);
   localparam int unsigned CBITS  = WIDTH_BITS + HEIGHT_BITS + 1;
   localparam int unsigned FRAME  = frame_pixels(WIDTH_BITS, HEIGHT_BITS);
   localparam int unsigned FBITS  = DEPTH_BITS + 1;
   localparam int unsigned FIFO_N = 2 ** DEPTH_BITS;

   state_t              state;
   state_t              state_d;
   logic [EBITS-1:0]    in_entry;
   logic [EBITS-1:0]    src_entry;
   logic [EBITS-1:0]    fifo_dout;
   logic                fifo_empty;
   logic [FBITS-1:0]    fifo_count;
   logic                fifo_push;
   logic                fifo_pop;
   logic                live;
   logic                room;
   logic                accept;
   logic                final_accept;
   logic                src_valid;
   logic                load;
   logic                push_ok;
   logic                drop;
   logic [CBITS-1:0]    done_cnt;

   assign in_entry = {bus.iRow, bus.iCol, bus.iData};

   plot_fifo #(
      .DATA_BITS  (EBITS),
      .DEPTH_BITS (DEPTH_BITS)
   ) u_fifo (
      .clock     (clock),
      .not_reset (not_reset),
      .clear     (bus.iClear),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .din       (in_entry),
      .dout      (fifo_dout),
      .full      (bus.oFull),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) state <= ST_EMPTY;
      else            state <= state_d;
   end

   // Next state, output-register load and FIFO push/pop decisions
   always_comb begin
      state_d      = state;
      load         = 1'b0;
      live         = (state != ST_DONE);
      room         = (fifo_count != FBITS'(FIFO_N));
      accept       = bus.oPlot && bus.iReady;
      final_accept = accept && (done_cnt == CBITS'(FRAME - 1));
      src_valid    = !fifo_empty || bus.iWren;

      case (state)
         ST_EMPTY: begin
            if (src_valid) begin
               load    = 1'b1;
               state_d = ST_PLOT;
            end
         end
         ST_PLOT: begin
            if (accept) begin
               if (final_accept) begin
                  state_d = ST_DONE;
               end else if (src_valid) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
         end
         default: ;
      endcase

      if (bus.iClear) begin
         state_d = ST_EMPTY;
         load    = 1'b0;
      end

      // With an empty FIFO the pushed pixel bypasses storage straight into the output register
      fifo_pop  = load && !fifo_empty;
      src_entry = fifo_empty ? in_entry : fifo_dout;
      push_ok   = bus.iWren && live && !bus.iClear && (room || fifo_pop);
      fifo_push = push_ok && !(load && fifo_empty);
      drop      = bus.iWren && live && !bus.iClear && !room && !fifo_pop;
   end

   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         bus.oX          <= '0;
         bus.oY          <= '0;
         bus.oR          <= '0;
         bus.oG          <= '0;
         bus.oB          <= '0;
         bus.oPlot       <= 1'b0;
         bus.oWhiteCount <= '0;
         bus.oFinished   <= 1'b0;
         bus.oOverflow   <= 1'b0;
         done_cnt        <= '0;
      end else if (bus.iClear) begin
         bus.oX          <= '0;
         bus.oY          <= '0;
         bus.oR          <= '0;
         bus.oG          <= '0;
         bus.oB          <= '0;
         bus.oPlot       <= 1'b0;
         bus.oWhiteCount <= '0;
         bus.oFinished   <= 1'b0;
         bus.oOverflow   <= 1'b0;
         done_cnt        <= '0;
      end else begin
         if (load) begin
            bus.oX <= src_entry[WIDTH_BITS:1];
            bus.oY <= src_entry[EBITS-1 -: HEIGHT_BITS];
            bus.oR <= {3{src_entry[0]}};
            bus.oG <= {3{src_entry[0]}};
            bus.oB <= {3{src_entry[0]}};
         end
         bus.oPlot     <= (state_d == ST_PLOT);
         bus.oFinished <= (state_d == ST_DONE);
         if (accept) begin
            done_cnt <= done_cnt + CBITS'(1);
            if (bus.oR[0]) bus.oWhiteCount <= bus.oWhiteCount + CBITS'(1);
         end
         if (drop) bus.oOverflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_result_plot_buffer.sv
// Randomized scoreboard bench for result_plot_buffer against a queue-based buffer model.
`timescale 1ns/1ps
module tb_result_plot_buffer;
   import result_plot_buffer_pkg::*;

   localparam int unsigned WB     = 8;
   localparam int unsigned HB     = 8;
   localparam int unsigned DB     = 4;
   localparam int          FIFO_N = 16;
   localparam int          FRAME  = 65536;

   typedef struct packed {
      logic [7:0] col;
      logic [7:0] row;
      logic       data;
   } pix_t;

   logic clk = 1'b0;
   logic not_reset = 1'b0;
   always #5 clk = ~clk;

   result_plot_buffer_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) bus ();

   result_plot_buffer #(
      .WIDTH_BITS  (WB),
      .HEIGHT_BITS (HB),
      .DEPTH_BITS  (DB)
   ) dut (
      .clock     (clk),
      .not_reset (not_reset),
      .bus       (bus)
   );

   // Model: every pixel held by the buffer, oldest first (head is on the display when plotting)
   pix_t mq[$];
   pix_t sb[$];
   int   m_cnt, m_white;
   bit   m_fin, m_ovf;
   int   pushed, ones_in;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_plot();
      return (mq.size() > 0) && !m_fin;
   endfunction

   function automatic int m_occ();
      return mq.size() - (m_plot() ? 1 : 0);
   endfunction

   task automatic model_clear();
      mq.delete();
      sb.delete();
      m_cnt   = 0;
      m_white = 0;
      m_fin   = 1'b0;
      m_ovf   = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs applied for that edge
   task automatic model_step();
      bit   acc, fin_before, head_moves;
      int   occ;
      pix_t p;
      if (bus.iClear) begin
         model_clear();
         return;
      end
      occ        = m_occ();
      fin_before = m_fin;
      acc        = m_plot() && bus.iReady;
      head_moves = 1'b0;
      if (acc) begin
         p = mq.pop_front();
         m_cnt++;
         if (p.data) m_white++;
         if (m_cnt == FRAME) m_fin = 1'b1;
         else                head_moves = (occ > 0);
      end
      if (bus.iWren && !fin_before) begin
         if (occ < FIFO_N || head_moves) begin
            p.col  = bus.iCol;
            p.row  = bus.iRow;
            p.data = bus.iData;
            mq.push_back(p);
            sb.push_back(p);
            pushed++;
            ones_in += int'(bus.iData);
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic step(input bit wren, input logic [7:0] col, input logic [7:0] row,
                       input bit data, input bit ready, input bit clr);
      bus.iWren  = wren;
      bus.iCol   = col;
      bus.iRow   = row;
      bus.iData  = data;
      bus.iReady = ready;
      bus.iClear = clr;
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic idle(input int n, input bit ready);
      for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, 1'b0, ready, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_plot"},  bus.oPlot, 0);
      check({tag, "_x"},     bus.oX, 0);
      check({tag, "_y"},     bus.oY, 0);
      check({tag, "_rgb"},   {bus.oR, bus.oG, bus.oB}, 0);
      check({tag, "_full"},  bus.oFull, 0);
      check({tag, "_white"}, bus.oWhiteCount, 0);
      check({tag, "_fin"},   bus.oFinished, 0);
      check({tag, "_ovf"},   bus.oOverflow, 0);
   endtask

   // Monitor: flags every cycle, pixel contents on every accept
   initial begin
      pix_t p;
      forever begin
         @(negedge clk);
         if (not_reset) begin
            check("mon_plot",  bus.oPlot, m_plot());
            check("mon_full",  bus.oFull, (m_occ() == FIFO_N));
            check("mon_ovf",   bus.oOverflow, m_ovf);
            check("mon_white", bus.oWhiteCount, m_white);
            check("mon_fin",   bus.oFinished, m_fin);
            if (bus.oPlot && bus.iReady && !bus.iClear) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL mon_unexpected_pixel x=%0d y=%0d with nothing expected", bus.oX, bus.oY);
               end else begin
                  checks--;
                  p = sb.pop_front();
                  check("mon_x",   bus.oX, p.col);
                  check("mon_y",   bus.oY, p.row);
                  check("mon_rgb", {bus.oR, bus.oG, bus.oB}, {9{p.data}});
               end
            end
         end
      end
   end

   initial begin
      bit frame_timeout;
      bus.iWren  = 1'b0;
      bus.iCol   = '0;
      bus.iRow   = '0;
      bus.iData  = 1'b0;
      bus.iReady = 1'b0;
      bus.iClear = 1'b0;
      model_clear();
      pushed  = 0;
      ones_in = 0;

      #22;
      check_reset_values("reset");
      @(posedge clk);
      #1;
      not_reset = 1'b1;

      // Four pixels, adapter always ready
      step(1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
      check("lat_plot", bus.oPlot, 1);
      check("lat_x", bus.oX, 0);
      step(1'b1, 8'd1, 8'd0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'd2, 8'd0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'd3, 8'd0, 1'b1, 1'b1, 1'b0);
      idle(2, 1'b1);
      check("four_white", bus.oWhiteCount, 3);
      check("four_drained", bus.oPlot, 0);

      // Fill: one in the output register plus sixteen in the FIFO
      for (int i = 0; i < 17; i++)
         step(1'b1, 8'(i + 16), 8'd1, 1'($urandom_range(1)), 1'b0, 1'b0);
      check("fill_full", bus.oFull, 1);
      check("fill_ovf", bus.oOverflow, 0);
      step(1'b1, 8'h40, 8'd2, 1'b1, 1'b1, 1'b0);
      check("pushpop_full", bus.oFull, 1);
      check("pushpop_ovf", bus.oOverflow, 0);
      step(1'b1, 8'hEE, 8'hEE, 1'b1, 1'b0, 1'b0);
      check("drop_ovf", bus.oOverflow, 1);
      idle(20, 1'b1);
      check("drop_drained", sb.size(), 0);

      // Clear while plotting with the FIFO half full, racing a push
      for (int i = 0; i < 9; i++)
         step(1'b1, 8'(i + 64), 8'd3, 1'($urandom_range(1)), 1'b0, 1'b0);
      step(1'b1, 8'h77, 8'h77, 1'b1, 1'b1, 1'b1);
      check("clr_plot", bus.oPlot, 0);
      check("clr_white", bus.oWhiteCount, 0);
      check("clr_full", bus.oFull, 0);
      check("clr_ovf", bus.oOverflow, 0);
      idle(6, 1'b1);

      // Asynchronous reset in the middle of a burst
      for (int i = 0; i < 5; i++)
         step(1'b1, 8'(i + 80), 8'd4, 1'b1, 1'b0, 1'b0);
      #2;
      not_reset = 1'b0;
      model_clear();
      #1;
      check_reset_values("arst");
      @(posedge clk);
      #1;
      not_reset = 1'b1;
      step(1'b1, 8'h55, 8'h66, 1'b0, 1'b1, 1'b0);
      check("arst_x", bus.oX, 8'h55);
      check("arst_y", bus.oY, 8'h66);
      check("arst_full", bus.oFull, 0);
      idle(3, 1'b1);

      // Whole frame with a stalling adapter
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      pushed  = 0;
      ones_in = 0;
      frame_timeout = 1'b1;
      for (int cyc = 0; cyc < 90000; cyc++) begin
         bit w;
         if (m_fin) begin
            frame_timeout = 1'b0;
            break;
         end
         w = (pushed < FRAME) && (m_occ() < FIFO_N);
         step(w, 8'(pushed), 8'(pushed >> 8), 1'($urandom_range(1)),
              ($urandom_range(15) != 0), 1'b0);
      end
      checks++;
      if (frame_timeout) begin
         errors++;
         $display("FAIL frame_timeout accepted=%0d required=%0d", m_cnt, FRAME);
      end
      check("frame_fin", bus.oFinished, 1);
      check("frame_plot", bus.oPlot, 0);
      check("frame_white", bus.oWhiteCount, ones_in);
      for (int i = 0; i < 4; i++)
         step(1'b1, 8'(i), 8'd0, 1'b1, 1'b1, 1'b0);
      check("after_fin", bus.oFinished, 1);
      check("after_ovf", bus.oOverflow, 0);
      check("after_plot", bus.oPlot, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
